ctrl_packet_initiator: RTL and testbench

CTRL_PACKET_INITIATOR -- requirements
Module: ctrl_packet_initiator

---
 rtl/ctrl_packet_initiator.sv | 171 +++++++++++++++++
 tb/tb_ctrl_packet_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_packet_initiator.sv
// Control-packet initiator: injects host register read/write packets into the
// stream between upstream words and waits for the matching read response.
module ctrl_packet_initiator #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned STREAM_ID_NUM  = 16,
  parameter int unsigned CHUNK_ID_NUM   = 32,
  parameter int unsigned CHANNEL_ID_NUM = 1024,
  parameter int unsigned STATE_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned SID = $clog2(STREAM_ID_NUM),
  localparam int unsigned CKW = $clog2(CHUNK_ID_NUM),
  localparam int unsigned CHW = $clog2(CHANNEL_ID_NUM)
) (
  input  logic                   clk,
  input  logic                   rstn,
  // host request
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [SID-1:0]         req_stream,
  input  logic [CHW-1:0]         req_hop,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  // host response
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_timeout,
  // upstream traffic
  input  logic [DATA_WIDTH-1:0]  up_Data,
  input  logic [1:0]             up_Type,
  input  logic                   up_Last,
  input  logic [SID-1:0]         up_StreamID,
  input  logic [CKW-1:0]         up_ChunkID,
  input  logic [CHW-1:0]         up_ChannelID,
  input  logic [STATE_WIDTH-1:0] up_State,
  // downstream traffic
  output logic [DATA_WIDTH-1:0]  out_Data,
  output logic [1:0]             out_Type,
  output logic                   out_Last,
  output logic [SID-1:0]         out_StreamID,
  output logic [CKW-1:0]         out_ChunkID,
  output logic [CHW-1:0]         out_ChannelID,
  output logic [STATE_WIDTH-1:0] out_State,
  // return loop
  input  logic [DATA_WIDTH-1:0]  ret_Data,
  input  logic [1:0]             ret_Type,
  input  logic                   ret_Last,
  input  logic [SID-1:0]         ret_StreamID,
  input  logic [CKW-1:0]         ret_ChunkID,
  input  logic [CHW-1:0]         ret_ChannelID,
  input  logic [STATE_WIDTH-1:0] ret_State
);

  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned WORDS = DATA_WIDTH / 32;

  typedef enum logic [1:0] {IDLE, INJECT, WAIT_RSP, RESP} state_t;

  state_t          state;
  logic            reqWrite;
  logic [SID-1:0]  reqStream;
  logic [CHW-1:0]  reqHop;
  logic [31:0]     reqAddr;
  logic [31:0]     reqWdata;
  logic [TW-1:0]   timer;
  logic            rspValid;
  logic [31:0]     rspData;
  logic            rspTimeout;
  logic            isMatch;
  logic            injectNow;
  logic            unusedRet;

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = rspValid;
  assign rsp_data    = rspData;
  assign rsp_timeout = rspTimeout;

  // Read response for the pending request's stream, judged in the cycle it appears.
  assign isMatch = ret_Type[1] && !ret_ChunkID[CKW-1]
                && (ret_ChunkID[CKW-2:0] == (CKW-1)'(1))
                && (ret_StreamID == reqStream);

  // Injection only takes a bubble in the upstream; busy words always win.
  assign injectNow = (state == INJECT) && (up_Type == 2'b00);

  assign unusedRet = ^{ret_Last, ret_ChannelID, ret_State, ret_Data[DATA_WIDTH-1:32]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      reqWrite      <= 1'b0;
      reqStream     <= '0;
      reqHop        <= '0;
      reqAddr       <= '0;
      reqWdata      <= '0;
      timer         <= '0;
      rspValid      <= 1'b0;
      rspData       <= '0;
      rspTimeout    <= 1'b0;
      out_Data      <= '0;
      out_Type      <= 2'b00;
      out_Last      <= 1'b0;
      out_StreamID  <= '0;
      out_ChunkID   <= '0;
      out_ChannelID <= '0;
      out_State     <= '0;
    end else begin
      if (injectNow) begin
        out_Data      <= reqWrite ? {WORDS{reqWdata}} : '0;
        out_Type      <= 2'b10;
        out_Last      <= 1'b1;
        out_StreamID  <= reqStream;
        out_ChunkID   <= {1'b1, (CKW-1)'(reqWrite)};
        out_ChannelID <= reqHop;
        out_State     <= STATE_WIDTH'(reqAddr);
      end else begin
        out_Data      <= up_Data;
        out_Type      <= up_Type;
        out_Last      <= up_Last;
        out_StreamID  <= up_StreamID;
        out_ChunkID   <= up_ChunkID;
        out_ChannelID <= up_ChannelID;
        out_State     <= up_State;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            reqWrite  <= req_write;
            reqStream <= req_stream;
            reqHop    <= req_hop;
            reqAddr   <= req_addr;
            reqWdata  <= req_wdata;
            state     <= INJECT;
          end
        end
        INJECT: begin
          if (injectNow) begin
            timer <= '0;
            state <= reqWrite ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A match in the final timer cycle still counts as a match.
          if (isMatch) begin
            rspValid   <= 1'b1;
            rspData    <= ret_Data[31:0];
            rspTimeout <= 1'b0;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            rspValid   <= 1'b1;
            rspData    <= '0;
            rspTimeout <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_packet_initiator.sv
// Directed bench for ctrl_packet_initiator: pass-through vector table plus
// hand-written write, read, busy, timeout, boundary-match and reset sequences.
module tb_ctrl_packet_initiator;

  localparam int unsigned DW = 512;
  localparam int unsigned TO = 24;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [3:0]    req_stream;
  logic [9:0]    req_hop;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0]   rsp_data;
  logic [DW-1:0] up_Data, out_Data, ret_Data;
  logic [1:0]    up_Type, out_Type, ret_Type;
  logic          up_Last, out_Last, ret_Last;
  logic [3:0]    up_StreamID, out_StreamID, ret_StreamID;
  logic [4:0]    up_ChunkID, out_ChunkID, ret_ChunkID;
  logic [9:0]    up_ChannelID, out_ChannelID, ret_ChannelID;
  logic [31:0]   up_State, out_State, ret_State;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  ctrl_packet_initiator #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_stream(req_stream), .req_hop(req_hop), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .up_Data(up_Data), .up_Type(up_Type), .up_Last(up_Last), .up_StreamID(up_StreamID),
    .up_ChunkID(up_ChunkID), .up_ChannelID(up_ChannelID), .up_State(up_State),
    .out_Data(out_Data), .out_Type(out_Type), .out_Last(out_Last), .out_StreamID(out_StreamID),
    .out_ChunkID(out_ChunkID), .out_ChannelID(out_ChannelID), .out_State(out_State),
    .ret_Data(ret_Data), .ret_Type(ret_Type), .ret_Last(ret_Last), .ret_StreamID(ret_StreamID),
    .ret_ChunkID(ret_ChunkID), .ret_ChannelID(ret_ChannelID), .ret_State(ret_State)
  );

  typedef struct {
    logic [1:0]  typ;  logic [31:0] word; logic last; logic [3:0] sid;
    logic [4:0]  ck;   logic [9:0]  ch;   logic [31:0] st;
    logic [1:0]  eTyp; logic [31:0] eWord; logic eLast; logic [3:0] eSid;
    logic [4:0]  eCk;  logic [9:0]  eCh;   logic [31:0] eSt;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [DW-1:0] rep32(input logic [31:0] w);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = w;
    return r;
  endfunction

  task automatic chkW(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleUp();
    up_Data = '0; up_Type = 2'b00; up_Last = 1'b0; up_StreamID = '0;
    up_ChunkID = '0; up_ChannelID = '0; up_State = '0;
  endtask

  task automatic clearRet();
    ret_Data = '0; ret_Type = 2'b00; ret_Last = 1'b0; ret_StreamID = '0;
    ret_ChunkID = '0; ret_ChannelID = '0; ret_State = '0;
  endtask

  task automatic setRet(input logic [1:0] t, input logic [4:0] ck, input logic [3:0] sid,
                        input logic [31:0] w);
    ret_Data = rep32(32'h1111_1111);
    ret_Data[31:0] = w;
    ret_Type = t; ret_ChunkID = ck; ret_StreamID = sid;
    ret_Last = 1'b1; ret_ChannelID = 10'd7; ret_State = 32'h99;
  endtask

  // Presents one request in IDLE; it is accepted at the next edge.
  task automatic issue(input logic wr, input logic [3:0] sid, input logic [9:0] hop,
                       input logic [31:0] addr, input logic [31:0] wd, input string nm);
    req_valid = 1'b1; req_write = wr; req_stream = sid; req_hop = hop;
    req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
    chk({nm, "_accepted"}, 32'(req_ready), 32'd0);
  endtask

  task automatic handshake(input string nm);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, "_rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] e;

    vecs[0] = '{2'b01, 32'h1234_5678, 1'b0, 4'd7, 5'd3, 10'd100, 32'hCAFE_0001,
                2'b01, 32'h1234_5678, 1'b0, 4'd7, 5'd3, 10'd100, 32'hCAFE_0001};
    vecs[1] = '{2'b11, 32'h8000_0001, 1'b1, 4'd15, 5'd31, 10'd1023, 32'hFFFF_FFFF,
                2'b11, 32'h8000_0001, 1'b1, 4'd15, 5'd31, 10'd1023, 32'hFFFF_FFFF};
    vecs[2] = '{2'b10, 32'h0BAD_F00D, 1'b1, 4'd2, 5'd1, 10'd4, 32'h0000_0044,
                2'b10, 32'h0BAD_F00D, 1'b1, 4'd2, 5'd1, 10'd4, 32'h0000_0044};
    vecs[3] = '{2'b00, 32'h0000_0000, 1'b0, 4'd0, 5'd0, 10'd0, 32'h0000_0000,
                2'b00, 32'h0000_0000, 1'b0, 4'd0, 5'd0, 10'd0, 32'h0000_0000};

    // Reset with busy upstream: outputs still forced to zero.
    rstn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_stream = '0; req_hop = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    clearRet();
    up_Data = rep32(32'hFFFF_0000); up_Type = 2'b01; up_Last = 1'b1;
    up_StreamID = 4'd5; up_ChunkID = 5'd9; up_ChannelID = 10'd9; up_State = 32'h5;
    repeat (3) step();
    chk("rst_out_type", 32'(out_Type), 32'd0);
    chkW("rst_out_data", out_Data, '0);
    chk("rst_out_last", 32'(out_Last), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    idleUp();
    @(negedge clk) rstn = 1'b1;
    step();

    // Pass-through table in IDLE: each word appears one edge later unchanged.
    for (int i = 0; i < 4; i++) begin
      d = rep32(vecs[i].word);
      d[31:0] = ~vecs[i].word;
      up_Data = d; up_Type = vecs[i].typ; up_Last = vecs[i].last;
      up_StreamID = vecs[i].sid; up_ChunkID = vecs[i].ck;
      up_ChannelID = vecs[i].ch; up_State = vecs[i].st;
      step();
      e = rep32(vecs[i].eWord);
      e[31:0] = ~vecs[i].eWord;
      chkW($sformatf("pt%0d_data", i), out_Data, e);
      chk($sformatf("pt%0d_type", i), 32'(out_Type), 32'(vecs[i].eTyp));
      chk($sformatf("pt%0d_last", i), 32'(out_Last), 32'(vecs[i].eLast));
      chk($sformatf("pt%0d_sid", i), 32'(out_StreamID), 32'(vecs[i].eSid));
      chk($sformatf("pt%0d_ck", i), 32'(out_ChunkID), 32'(vecs[i].eCk));
      chk($sformatf("pt%0d_ch", i), 32'(out_ChannelID), 32'(vecs[i].eCh));
      chk($sformatf("pt%0d_st", i), out_State, vecs[i].eSt);
      chk($sformatf("pt%0d_ready", i), 32'(req_ready), 32'd1);
    end
    idleUp();
    step();

    // Write: injected one edge after acceptance, no host response.
    issue(1'b1, 4'd1, 10'd3, 32'h10, 32'hA5A5_A5A5, "wr");
    step();
    chk("wr_type", 32'(out_Type), 32'd2);
    chk("wr_last", 32'(out_Last), 32'd1);
    chk("wr_chunk", 32'(out_ChunkID), 32'b10001);
    chk("wr_hop", 32'(out_ChannelID), 32'd3);
    chk("wr_sid", 32'(out_StreamID), 32'd1);
    chk("wr_state", out_State, 32'h10);
    chkW("wr_data", out_Data, rep32(32'hA5A5_A5A5));
    chk("wr_ready", 32'(req_ready), 32'd1);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("wr_after_type", 32'(out_Type), 32'd0);
    chk("wr_after_no_rsp", 32'(rsp_valid), 32'd0);

    // Read with mismatching returns ignored, then a match 20 cycles in.
    issue(1'b0, 4'd2, 10'd0, 32'h4, 32'hFFFF_FFFF, "rd");
    step();
    chk("rd_type", 32'(out_Type), 32'd2);
    chk("rd_chunk", 32'(out_ChunkID), 32'b10000);
    chkW("rd_data", out_Data, '0);
    chk("rd_hop", 32'(out_ChannelID), 32'd0);
    chk("rd_state", out_State, 32'h4);
    chk("rd_sid", 32'(out_StreamID), 32'd2);
    chk("rd_busy", 32'(req_ready), 32'd0);
    for (int c = 0; c < 20; c++) begin
      if (c == 5)      setRet(2'b10, 5'b00001, 4'd3, 32'h3333_3333);
      else if (c == 6) setRet(2'b01, 5'b00001, 4'd2, 32'h6666_6666);
      else if (c == 7) setRet(2'b10, 5'b10001, 4'd2, 32'h7777_7777);
      else if (c == 8) setRet(2'b10, 5'b00010, 4'd2, 32'h8888_8888);
      else             clearRet();
      step();
      chk($sformatf("rd_wait%0d_no_rsp", c), 32'(rsp_valid), 32'd0);
    end
    setRet(2'b10, 5'b00001, 4'd2, 32'hDEAD_BEEF);
    step();
    clearRet();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
    chk("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) setRet(2'b10, 5'b00001, 4'd2, 32'h0BAD_0BAD);
      else        clearRet();
      step();
      chk($sformatf("rd_hold%0d_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("rd_hold%0d_data", c), rsp_data, 32'hDEAD_BEEF);
      chk($sformatf("rd_hold%0d_ready", c), 32'(req_ready), 32'd0);
    end
    clearRet();

    // Completion cycle refuses a waiting request; it is taken one cycle later.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_stream = 4'd0; req_hop = 10'd1;
    req_addr = 32'h8; req_wdata = 32'h5A5A_5A5A;
    step();
    rsp_ready = 1'b0;
    chk("cmpl_rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("cmpl_not_taken", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("cmpl_taken_next", 32'(req_ready), 32'd0);
    step();
    chk("cmpl_wr_chunk", 32'(out_ChunkID), 32'b10001);
    chkW("cmpl_wr_data", out_Data, rep32(32'h5A5A_5A5A));
    chk("cmpl_wr_ready", 32'(req_ready), 32'd1);

    // Busy upstream holds off injection; busy words forward untouched.
    issue(1'b0, 4'd2, 10'd5, 32'h20, 32'h0, "busy");
    for (int i = 0; i < 5; i++) begin
      up_Type = 2'b01; up_Data = rep32(32'hB000_0000 + 32'(i)); up_StreamID = 4'(i);
      up_Last = (i == 4); up_ChunkID = 5'(i + 8); up_ChannelID = 10'(i * 3);
      up_State = 32'hF00 + 32'(i);
      step();
      chk($sformatf("busy%0d_type", i), 32'(out_Type), 32'd1);
      chkW($sformatf("busy%0d_data", i), out_Data, rep32(32'hB000_0000 + 32'(i)));
      chk($sformatf("busy%0d_sid", i), 32'(out_StreamID), 32'(i));
      chk($sformatf("busy%0d_last", i), 32'(out_Last), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("busy%0d_state", i), out_State, 32'hF00 + 32'(i));
      chk($sformatf("busy%0d_ready", i), 32'(req_ready), 32'd0);
    end
    idleUp();
    step();
    chk("busy_inj_type", 32'(out_Type), 32'd2);
    chk("busy_inj_chunk", 32'(out_ChunkID), 32'b10000);
    chk("busy_inj_hop", 32'(out_ChannelID), 32'd5);
    chk("busy_inj_state", out_State, 32'h20);

    // Timeout: TO waiting cycles, a foreign-stream response in between.
    for (int c = 0; c < TO - 1; c++) begin
      if (c == 2) setRet(2'b10, 5'b00001, 4'd3, 32'h3333_3333);
      else        clearRet();
      step();
      chk($sformatf("to_wait%0d", c), 32'(rsp_valid), 32'd0);
    end
    clearRet();
    step();
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    handshake("to");

    // Match arriving in the final timer cycle wins over the timeout.
    issue(1'b0, 4'd9, 10'd2, 32'h30, 32'h0, "edge");
    step();
    for (int c = 0; c < TO - 1; c++) begin
      step();
      chk($sformatf("edge_wait%0d", c), 32'(rsp_valid), 32'd0);
    end
    setRet(2'b11, 5'b00001, 4'd9, 32'hC0FF_EE01);
    step();
    clearRet();
    chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("edge_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("edge_rsp_data", rsp_data, 32'hC0FF_EE01);
    handshake("edge");

    // Reset during WAIT_RSP abandons the read; the late response is dropped.
    issue(1'b0, 4'd2, 10'd1, 32'h40, 32'h0, "rst");
    step();
    up_Type = 2'b01; up_Data = rep32(32'h1357_9BDF); up_Last = 1'b1;
    repeat (3) step();
    @(negedge clk) rstn = 1'b0;
    #1;
    chk("mid_rst_type", 32'(out_Type), 32'd0);
    chkW("mid_rst_data", out_Data, '0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    step();
    idleUp();
    @(negedge clk) rstn = 1'b1;
    setRet(2'b10, 5'b00001, 4'd2, 32'h7777_0001);
    step();
    clearRet();
    chk("late_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late_rsp_data", rsp_data, 32'd0);
    chk("late_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("late_ready", 32'(req_ready), 32'd1);
    step();
    chk("late_rsp_valid2", 32'(rsp_valid), 32'd0);
    chk("late_out_type", 32'(out_Type), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
